// File: rtl/cdc_word_qualifier_if.sv
// Bundle between the word qualifier and its neighbours: the sampled word stream
// and flush coming in, and the show-ahead FIFO port and its status going out.
interface cdc_word_qualifier_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] sync_data;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              ovf;
  logic [LVL_W-1:0]  level;

  modport master (
    input  sync_data, flush, m_ready,
    output m_valid, m_data, ovf, level
  );

  modport slave (
    output sync_data, flush, m_ready,
    input  m_valid, m_data, ovf, level
  );
endinterface

// File: rtl/cdc_word_qualifier.sv
// Qualifies a free-running CDC word stream once it has been steady for STABLE_CNT
// cycles and emits each newly qualified value once through a show-ahead FIFO.
module cdc_word_qualifier #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  cdc_word_qualifier_if.master q
);

  localparam int unsigned     PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]      RUN_MAX  = 4'd15;
  localparam logic [3:0]      RUN_TGT  = 4'(STABLE_CNT);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] samp_q, samp_d;
  logic [3:0]        run_q, run_d;
  logic              have_last_q, have_last_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;

  logic commit;
  logic m_valid;
  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;

  // Commit fires only at the exact run count, so a saturated run never re-fires.
  always_comb begin
    commit  = (run_q == RUN_TGT) && (!have_last_q || (samp_q != last_q));
    m_valid = (level_q != '0);
    full    = (level_q == LVL_FULL);
    pop     = m_valid && q.m_ready && !q.flush;
    push    = commit && !q.flush;
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_comb begin
    samp_d      = q.sync_data;
    run_d       = 4'd1;
    have_last_d = have_last_q;
    last_d      = last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;

    // A flush restarts the run at the current sample so a steady word
    // re-qualifies STABLE_CNT edges after the flush edge.
    if (!q.flush && (q.sync_data == samp_q) && (run_q != 4'd0)) begin
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
    end

    if (q.flush) begin
      have_last_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      ovf_d       = 1'b0;
    end else begin
      if (commit) begin
        last_d      = samp_q;
        have_last_d = 1'b1;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
      ovf_d   = ovf_q | drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q      <= '0;
      run_q       <= '0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      run_q       <= run_d;
      have_last_q <= have_last_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= samp_q;
    end
  end

  // Gating m_data by m_valid keeps it at zero after reset without clearing storage.
  assign q.m_valid = m_valid;
  assign q.m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign q.ovf     = ovf_q;
  assign q.level   = level_q;

endmodule

// File: tb/tb_cdc_word_qualifier.sv
// Self-checking bench for cdc_word_qualifier: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_cdc_word_qualifier;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STABLE_CNT = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdc_word_qualifier_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  cdc_word_qualifier #(
    .DATA_W    (DATA_W),
    .STABLE_CNT(STABLE_CNT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q  (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: run length of the current sample, last committed word, output queue.
  logic [DATA_W-1:0] m_samp;
  int unsigned       m_run;
  bit                m_have;
  logic [DATA_W-1:0] m_last;
  logic [DATA_W-1:0] exp_q[$];
  bit                m_ovf;

  task automatic model_reset();
    m_samp = '0; m_run = 0; m_have = 0; m_last = '0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [DATA_W-1:0] d, input logic fl, input logic rdy);
    bit commit;
    commit = (m_run == STABLE_CNT) && (!m_have || m_samp != m_last);
    if (fl) begin
      exp_q.delete(); m_ovf = 0; m_have = 0; m_run = 1;
    end else begin
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (commit) begin
        m_last = m_samp; m_have = 1;
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(m_samp);
        else m_ovf = 1;
      end
      m_run = (d == m_samp && m_run != 0) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
    end
    m_samp = d;
  endtask

  // Drive one cycle from a negedge: inputs, active edge, model update, back to negedge.
  task automatic cycle(input logic [DATA_W-1:0] d, input logic fl, input logic rdy);
    bus.sync_data = d; bus.flush = fl; bus.m_ready = rdy;
    @(posedge clk);
    model_step(d, fl, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.sync_data = '0; bus.flush = 1'b0; bus.m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_word(input logic [DATA_W-1:0] w);
    repeat (STABLE_CNT + 1) cycle(w, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.sync_data = 32'h1234_5678; bus.flush = 1'b0; bus.m_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%0b exp=0", bus.m_valid); end
    n_vec++; if (bus.m_data !== '0) begin n_err++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
    n_vec++; if (bus.level !== '0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    do_reset();
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] w;
    w = 32'hA5A5_0001;
    do_reset();
    cycle(w, 1'b0, 1'b0);
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_k got=%0b exp=0", bus.m_valid); end
    cycle(w, 1'b0, 1'b0);
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_k1 got=%0b exp=0", bus.m_valid); end
    cycle(w, 1'b0, 1'b0);
    n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL lat_k2_valid got=%0b exp=1", bus.m_valid); end
    n_vec++; if (bus.m_data !== w) begin n_err++; $display("FAIL lat_k2_data got=%h exp=%h", bus.m_data, w); end
    repeat (3) cycle(w, 1'b0, 1'b0);
    n_vec++; if (bus.level !== LVL_W'(1)) begin n_err++; $display("FAIL lat_single_emit got=%0d exp=1", bus.level); end
    n_vec++; if (bus.m_data !== w) begin n_err++; $display("FAIL lat_hold_data got=%h exp=%h", bus.m_data, w); end
    cycle(w, 1'b0, 1'b1);
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_pop_valid got=%0b exp=0", bus.m_valid); end
    repeat (4) cycle(w, 1'b0, 1'b1);
    n_vec++; if (bus.level !== '0) begin n_err++; $display("FAIL lat_no_reemit got=%0d exp=0", bus.level); end
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (4) cycle(32'h22, 1'b0, 1'b0);
    cycle(32'h11, 1'b0, 1'b0);
    repeat (4) cycle(32'h22, 1'b0, 1'b0);
    n_vec++; if (bus.level !== LVL_W'(1)) begin n_err++; $display("FAIL glitch_level got=%0d exp=1", bus.level); end
    n_vec++; if (bus.m_data !== 32'h22) begin n_err++; $display("FAIL glitch_data got=%h exp=22", bus.m_data); end
    cycle(32'h22, 1'b0, 1'b1);
    n_vec++; if (bus.level !== '0) begin n_err++; $display("FAIL glitch_drain got=%0d exp=0", bus.level); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int unsigned i = 1; i <= 4; i++) load_word(DATA_W'(i));
    n_vec++; if (bus.level !== LVL_W'(4)) begin n_err++; $display("FAIL bp_level4 got=%0d exp=4", bus.level); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL bp_no_ovf got=%0b exp=0", bus.ovf); end
    load_word(32'h5);
    n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf got=%0b exp=1", bus.ovf); end
    n_vec++; if (bus.level !== LVL_W'(4)) begin n_err++; $display("FAIL bp_level_full got=%0d exp=4", bus.level); end
    for (int unsigned i = 1; i <= 4; i++) begin
      n_vec++; if (bus.m_data !== DATA_W'(i)) begin n_err++; $display("FAIL bp_order got=%h exp=%h", bus.m_data, DATA_W'(i)); end
      cycle(32'h5, 1'b0, 1'b1);
    end
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%0b exp=0", bus.m_valid); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int unsigned i = 1; i <= 4; i++) load_word(DATA_W'(i));
    repeat (STABLE_CNT) cycle(32'h5, 1'b0, 1'b0);
    cycle(32'h5, 1'b0, 1'b1);
    n_vec++; if (bus.level !== LVL_W'(4)) begin n_err++; $display("FAIL fullpop_level got=%0d exp=4", bus.level); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got=%0b exp=0", bus.ovf); end
    for (int unsigned i = 2; i <= 5; i++) begin
      n_vec++; if (bus.m_data !== DATA_W'(i)) begin n_err++; $display("FAIL fullpop_order got=%h exp=%h", bus.m_data, DATA_W'(i)); end
      cycle(32'h5, 1'b0, 1'b1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int unsigned i = 1; i <= 5; i++) load_word(DATA_W'(i));
    cycle(32'h5, 1'b0, 1'b1);
    n_vec++; if (bus.level !== LVL_W'(3) || bus.ovf !== 1'b1) begin n_err++; $display("FAIL flush_pre got=%0d/%0b exp=3/1", bus.level, bus.ovf); end
    cycle(32'h5, 1'b1, 1'b0);
    n_vec++; if (bus.level !== '0) begin n_err++; $display("FAIL flush_level got=%0d exp=0", bus.level); end
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%0b exp=0", bus.m_valid); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL flush_ovf got=%0b exp=0", bus.ovf); end
    cycle(32'h5, 1'b0, 1'b0);
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_early got=%0b exp=0", bus.m_valid); end
    cycle(32'h5, 1'b0, 1'b0);
    n_vec++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h5) begin n_err++; $display("FAIL flush_reemit got=%0b/%h exp=1/5", bus.m_valid, bus.m_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_word(32'hAA);
    load_word(32'hBB);
    n_vec++; if (bus.level !== LVL_W'(2)) begin n_err++; $display("FAIL arst_pre got=%0d exp=2", bus.level); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%0b exp=0", bus.m_valid); end
    n_vec++; if (bus.m_data !== '0) begin n_err++; $display("FAIL arst_data got=%h exp=0", bus.m_data); end
    n_vec++; if (bus.level !== '0) begin n_err++; $display("FAIL arst_level got=%0d exp=0", bus.level); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] alpha [4];
    logic [DATA_W-1:0] exp_data;
    alpha[0] = 32'h22; alpha[1] = 32'h11; alpha[2] = 32'hA5A5_0001; alpha[3] = 32'hDEAD_BEEF;
    do_reset();
    d = alpha[0];
    for (int unsigned n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) d = alpha[$urandom_range(0, 3)];
      cycle(d, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
      exp_data = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_vec++; if (bus.m_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, bus.m_valid, exp_q.size() > 0); end
      n_vec++; if (bus.m_data !== exp_data) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, bus.m_data, exp_data); end
      n_vec++; if (bus.level !== LVL_W'(exp_q.size())) begin n_err++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, bus.level, exp_q.size()); end
      n_vec++; if (bus.ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", n, bus.ovf, m_ovf); end
    end
  endtask

  initial begin
    bus.sync_data = '0; bus.flush = 1'b0; bus.m_ready = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
